ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port matrix RAM (ram_d words of data_w bits) between two masters.
  - Port 0: host loader/dumper, which writes the header and operands and reads results.
  - Port 1: matrix multiplier control unit.
- Registered-grant arbiter with round-robin on ties and a hold limit to bound starvation.
- A lock input lets a master keep ownership across a multi-word burst.
- Sits between both masters and the RAM; RAM read latency is 1 cycle.

Parameters:
- data_w, 32, RAM word width.
- ram_d, 512, RAM depth in words.
- ram_add_w, $clog2(ram_d), address width.
- MAX_HOLD, 16, cycles an unlocked owner keeps the grant while the other port is requesting; legal range 1 to 255.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1 each  access request; held high for as long as the master wants ownership.
- lock0, lock1  in  1 each  suppresses hold-limit pre-emption while high.
- we0, we1  in  1 each  write enable for the current access.
- addr0, addr1  in  ram_add_w each  access address.
- wdata0, wdata1  in  data_w each  write data.
- gnt0, gnt1  out  1 each  registered grant; at most one high.
- rvalid0, rvalid1  out  1 each  rdata carries this port's read result.
- rdata  out  data_w  equals ram_r_data (pass-through, shared by both ports).
- ram_we  out  1  to RAM.
- ram_addr  out  ram_add_w  to RAM.
- ram_w_data  out  data_w  to RAM.
- ram_r_data  in  data_w  from RAM; valid 1 cycle after the address.

Behaviour:
- State register, encoded in the package: IDLE=0, OWN0=1, OWN1=2.
- Grant decode: gnt0 = (state==OWN0), gnt1 = (state==OWN1); both are registered decodes.
- Other registers:
  - rr_last: 1 bit, last port granted.
  - hold_cnt: 8 bits, saturating.
- Reset (async, immediate):
  - state=IDLE, rr_last=1 (so port 0 wins the first tie), hold_cnt=0.
  - gnt0/gnt1=0, rvalid0/rvalid1=0, ram_we=0.
  - A reset mid-burst aborts the burst; no write completes after rst rises.
- Access rule:
  - A RAM access occurs in any cycle where gntX && reqX.
  - ram_addr, ram_w_data and ram_we are muxed combinationally from the owner.
  - ram_we = weX only when gntX && reqX; otherwise 0.
  - When there is no owner, ram_addr=0 and ram_w_data=0.
- Read return: rvalidX <= gntX && reqX && !weX. Data is on rdata in the same cycle as rvalidX (1-cycle latency).
- Grant latency: req rising in IDLE gives gnt on the next cycle. The request cycle itself performs no access.
- Transitions out of IDLE:
  - Only req0 → OWN0.
  - Only req1 → OWN1.
  - Both → port != rr_last.
  - Neither → stay in IDLE.
- Transitions out of OWNx (y = other port):
  - !reqX && reqY → OWNy.
  - !reqX && !reqY → IDLE.
  - reqX && reqY && !lockX && hold_cnt == MAX_HOLD-1 → OWNy (pre-emption).
  - Otherwise stay in OWNx; hold_cnt increments (saturating) only while reqY is high.
- On every state entry: hold_cnt=0; rr_last=x on entering OWNx.
- Direct handover: OWN0→OWN1 and back with no IDLE bubble. The new owner's first access is in the cycle after the switch edge.
- Dropping the grant: in the cycle reqX falls, gntX is still high but no access happens (ram_we=0). The grant drops at the next edge.
- Pre-emption: the master sees gntX fall while reqX is still high. That master holds its address/data and keeps req high until re-granted.
- Lock: with lockX high, the owner holds indefinitely while reqX is high. Lock has no effect on a master that is not the owner.
- rvalid/grant overlap: a read issued in the last owned cycle still returns rvalidX on the following cycle, even though gntY is then high.
- Invariant: gnt0 && gnt1 is never true. The bench asserts this every cycle.

Decomposition:
- Package ram_arb_pkg holds:
  - state encodings IDLE/OWN0/OWN1;
  - HOLD_CNT_W=8;
  - port index constants P_HOST=0, P_CU=1.
- One flat module; no sub-module is natural. The hold counter and the output mux are a few lines each.

Test Plan:
- Reset, then req0 alone writes addr 0 = 0x0302_0302, then reads addr 0 → gnt0 one cycle after req0; rvalid0 with rdata 0x03020302 one cycle after the read; gnt1 stays 0.
- req0 and req1 rise together after reset → gnt0 first. Port 0 drops req after 3 accesses → gnt1 the next cycle with no IDLE gap. Next tie → gnt1 wins (rr_last=0).
- Both requesting continuously, locks low, MAX_HOLD=4 → grant alternates every 4 cycles; each port completes exactly 4 accesses per tenure.
- lock0 high with both requesting for 40 cycles → gnt0 is held all 40 cycles. lock0 falls → gnt1 within MAX_HOLD cycles.
- Port 1 reads addr 5 in its last owned cycle while the grant switches to port 0 → rvalid1 the next cycle with mem[5]; rvalid0 stays 0 that cycle.
- rst pulsed mid-burst while OWN1 with we1=1 → gnt1, ram_we and rvalid go 0 immediately. No further write; state is IDLE after rst falls.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants for the matrix-RAM port arbiter: state encodings,
// hold counter width and port indices.
package ram_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int unsigned HOLD_CNT_W = 8;

  localparam logic P_HOST = 1'b0;
  localparam logic P_CU   = 1'b1;

endpackage

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port matrix RAM: registered grant,
// round-robin on ties, hold-limit pre-emption and per-port lock.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int data_w    = 32,
  parameter int ram_d     = 512,
  parameter int ram_add_w = $clog2(ram_d),
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ram_add_w-1:0] addr0,
  input  logic [ram_add_w-1:0] addr1,
  input  logic [data_w-1:0]    wdata0,
  input  logic [data_w-1:0]    wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [data_w-1:0]    rdata,
  output logic                 ram_we,
  output logic [ram_add_w-1:0] ram_addr,
  output logic [data_w-1:0]    ram_w_data,
  input  logic [data_w-1:0]    ram_r_data
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  r_rr_last;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_acc0;
  logic                  w_acc1;
  logic                  w_hold_hit;
  logic                  w_contended;

  assign w_gnt0 = (r_state == OWN0);
  assign w_gnt1 = (r_state == OWN1);
  assign w_acc0 = w_gnt0 && req0;
  assign w_acc1 = w_gnt1 && req1;
  // After a lock is released the count may already be past the limit;
  // >= lets pre-emption fire at once instead of never matching.
  assign w_hold_hit  = (r_hold_cnt >= HOLD_LIM);
  assign w_contended = (w_gnt0 && req1) || (w_gnt1 && req0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1)  w_next = (r_rr_last == P_HOST) ? OWN1 : OWN0;
        else if (req0)     w_next = OWN0;
        else if (req1)     w_next = OWN1;
      end
      OWN0: begin
        if (!req0)                                  w_next = req1 ? OWN1 : IDLE;
        else if (req1 && !lock0 && w_hold_hit)      w_next = OWN1;
      end
      OWN1: begin
        if (!req1)                                  w_next = req0 ? OWN0 : IDLE;
        else if (req0 && !lock1 && w_hold_hit)      w_next = OWN0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_last  <= P_CU;
      r_hold_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rvalid0 <= w_acc0 && !we0;
      r_rvalid1 <= w_acc1 && !we1;
      if (w_next != r_state) begin
        r_hold_cnt <= '0;
        if (w_next == OWN0)      r_rr_last <= P_HOST;
        else if (w_next == OWN1) r_rr_last <= P_CU;
      end else if (w_contended && (r_hold_cnt != '1)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign rvalid0    = r_rvalid0;
  assign rvalid1    = r_rvalid1;
  assign rdata      = ram_r_data;
  assign ram_we     = (w_acc0 && we0) || (w_acc1 && we1);
  assign ram_addr   = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
  assign ram_w_data = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against an ownership
// and shadow-memory reference model.
module tb_ram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata, ram_w_data;
  logic [DW-1:0] ram_r_data = '0;
  logic [AW-1:0] ram_addr;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter #(.data_w(DW), .ram_d(512), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read latency
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_w_data;
    ram_r_data <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, who was last served, how many
  // contended cycles the current owner has used, expected memory contents.
  int            m_owner = -1;
  bit            m_last  = 1'b1;
  int            m_cont  = 0;
  bit            m_rv0   = 1'b0;
  bit            m_rv1   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] shadow [512];

  task automatic model_reset();
    m_owner = -1; m_last = 1'b1; m_cont = 0; m_rv0 = 1'b0; m_rv1 = 1'b0;
  endtask

  task automatic model_edge();
    bit            r [2];
    bit            l [2];
    bit            w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    int            nxt, x, y;
    r[0] = req0;  r[1] = req1;  l[0] = lock0; l[1] = lock1;
    w[0] = we0;   w[1] = we1;   a[0] = addr0; a[1] = addr1;
    d[0] = wdata0; d[1] = wdata1;
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    if (m_owner >= 0 && r[m_owner]) begin
      if (w[m_owner]) shadow[a[m_owner]] = d[m_owner];
      else begin
        m_rdata = shadow[a[m_owner]];
        if (m_owner == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
      end
    end
    nxt = m_owner;
    if (m_owner < 0) begin
      if (r[0] && r[1]) nxt = m_last ? 0 : 1;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
    end else begin
      x = m_owner; y = 1 - x;
      if (!r[x])                                      nxt = r[y] ? y : -1;
      else if (r[y] && !l[x] && (m_cont + 1) >= MH)   nxt = y;
    end
    if (nxt != m_owner) begin
      m_cont = 0;
      if (nxt >= 0) m_last = (nxt == 1);
    end else if (m_owner >= 0 && r[1 - m_owner]) begin
      m_cont++;
    end
    m_owner = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  initial begin
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (m_owner == 0) begin e_we = req0 && we0; e_addr = addr0; e_wd = wdata0; end
        if (m_owner == 1) begin e_we = req1 && we1; e_addr = addr1; e_wd = wdata1; end
        chk("gnt0", gnt0, (m_owner == 0));
        chk("gnt1", gnt1, (m_owner == 1));
        chk("excl", gnt0 && gnt1, 1'b0);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_w_data", ram_w_data, e_wd);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic idle_all();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    int            n;
    bit            seen;
    logic [DW-1:0] v5, va, vb;
    for (int i = 0; i < 512; i++) begin mem[i] = '0; shadow[i] = '0; end

    cyc(2);
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_rv0", rvalid0, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    rst = 1'b0;

    // single host write then read of addr 0
    req0 = 1; we0 = 1; addr0 = '0; wdata0 = 32'h0302_0302;
    mid();
    chk("t1_nogrant_yet", gnt0, 1'b0);
    cyc(1);
    mid();
    chk("t1_grant", gnt0, 1'b1);
    cyc(1);
    we0 = 0;
    cyc(1);
    req0 = 0;
    mid();
    chk("t1_rvalid0", rvalid0, 1'b1);
    chk("t1_rdata", rdata, 32'h0302_0302);
    chk("t1_gnt1", gnt1, 1'b0);
    cyc(2);

    // tie after reset, port 0 drops after 3 accesses
    do_reset();
    req0 = 1; req1 = 1; addr0 = 9'd1; addr1 = 9'd2;
    cyc(1);
    mid();
    chk("tie1_gnt0", gnt0, 1'b1);
    cyc(3);
    req0 = 0;
    cyc(1);
    mid();
    chk("handover_gnt1", gnt1, 1'b1);
    cyc(2);
    req1 = 0;
    cyc(2);
    req0 = 1;
    cyc(3);
    req0 = 0;
    cyc(2);
    req0 = 1; req1 = 1;
    cyc(1);
    mid();
    chk("tie2_gnt1", gnt1, 1'b1);

    // continuous contention, random accesses
    for (int i = 0; i < 24; i++) begin
      we0 = $urandom_range(1); we1 = $urandom_range(1);
      addr0 = AW'($urandom_range(15)); addr1 = AW'($urandom_range(15));
      wdata0 = $urandom; wdata1 = $urandom;
      cyc(1);
    end
    idle_all();
    cyc(2);

    // lock0 holds the grant for 40 contended cycles
    req0 = 1; lock0 = 1; addr0 = 9'd3;
    cyc(1);
    req1 = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (gnt0) n++;
      cyc(1);
    end
    chk("lock_hold", n, 40);
    lock0 = 0;
    seen = 0;
    for (int i = 0; i < MH + 1 && !seen; i++) begin
      cyc(1);
      mid();
      if (gnt1) seen = 1;
    end
    chk("lock_release", seen, 1'b1);
    idle_all();
    cyc(2);

    // port 1 reads addr 5 up to the cycle it is pre-empted
    v5 = $urandom;
    req1 = 1; we1 = 1; addr1 = 9'd5; wdata1 = v5;
    cyc(2);
    we1 = 0; req0 = 1; addr0 = 9'd7;
    seen = 0;
    for (int i = 0; i < MH + 3 && !seen; i++) begin
      cyc(1);
      mid();
      if (gnt0) begin
        seen = 1;
        chk("last_rv1", rvalid1, 1'b1);
        chk("last_rdata", rdata, v5);
        chk("last_rv0", rvalid0, 1'b0);
      end
    end
    chk("preempt_seen", seen, 1'b1);
    idle_all();
    cyc(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(3) != 0); req1 = ($urandom_range(3) != 0);
      lock0 = ($urandom_range(7) == 0); lock1 = ($urandom_range(7) == 0);
      we0 = $urandom_range(1); we1 = $urandom_range(1);
      addr0 = AW'($urandom_range(15)); addr1 = AW'($urandom_range(15));
      wdata0 = $urandom; wdata1 = $urandom;
      cyc(1);
    end
    idle_all();
    cyc(3);

    // reset mid-burst while port 1 writes
    va = 32'hA5A5_0001; vb = 32'h5A5A_0002;
    req1 = 1; we1 = 1; addr1 = 9'd9; wdata1 = va;
    cyc(3);
    wdata1 = vb;
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_gnt1", gnt1, 1'b0);
    chk("mrst_we", ram_we, 1'b0);
    chk("mrst_rv0", rvalid0, 1'b0);
    chk("mrst_rv1", rvalid1, 1'b0);
    cyc(2);
    rst = 1'b0;
    idle_all();
    cyc(1);
    mid();
    chk("post_rst_gnt0", gnt0, 1'b0);
    chk("post_rst_gnt1", gnt1, 1'b0);
    req0 = 1; we0 = 0; addr0 = 9'd9;
    cyc(2);
    mid();
    chk("post_rst_rv0", rvalid0, 1'b1);
    chk("post_rst_rdata", rdata, va);
    idle_all();
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
